// File: rtl/ysyx_24080014_wb_ctrl.sv
// Write-back controller: takes one instruction from execute, waits for the memory
// response when needed (with a timeout), then issues a one-cycle commit with GPR/CSR writes.
module ysyx_24080014_wb_ctrl #(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_pc,
   input  logic [4:0]  in_rd,
   input  logic [31:0] in_rd_data,
   input  logic        in_reg_wr,
   input  logic        in_load,
   input  logic        in_store,
   input  logic [1:0]  in_csr_ctl,
   input  logic [11:0] in_csr_addr,
   input  logic [31:0] in_csr_data,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   input  logic        mem_bvalid,
   output logic        gpr_we,
   output logic [4:0]  gpr_waddr,
   output logic [31:0] gpr_wdata,
   output logic        csr_we,
   output logic [11:0] csr_waddr,
   output logic [31:0] csr_wdata,
   output logic        ecall_we,
   output logic [31:0] ecall_pc,
   output logic        commit_valid,
   output logic [31:0] commit_pc,
   output logic        commit_err
);

   localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_WAIT_MEM, S_COMMIT} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             err_p1, err_nxt;

   logic [31:0] pc_p1;
   logic [4:0]  rd_p1;
   logic [31:0] rd_data_p1;
   logic        reg_wr_p1;
   logic        load_p1;
   logic        store_p1;
   logic [1:0]  csr_ctl_p1;
   logic [11:0] csr_addr_p1;
   logic [31:0] csr_data_p1;
   logic [31:0] mem_data_p1;

   logic hs;
   logic resp;
   logic commit;

   function automatic logic csr_writable(input logic [11:0] a);
      return (a == 12'h300) || (a == 12'h305) || (a == 12'h341) || (a == 12'h342);
   endfunction

   assign hs   = in_valid && (state == S_IDLE);
   // Only the response kind matching the pending access counts; the other is ignored.
   assign resp = load_p1 ? mem_rvalid : (store_p1 && mem_bvalid);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      err_nxt   = err_p1;
      case (state)
         S_IDLE: begin
            if (in_valid) begin
               state_nxt = (in_load || in_store) ? S_WAIT_MEM : S_COMMIT;
               cnt_nxt   = '0;
               err_nxt   = 1'b0;
            end
         end
         S_WAIT_MEM: begin
            // A response arriving on the final count still wins over the timeout.
            if (resp) begin
               state_nxt = S_COMMIT;
            end else if (cnt == CNT_MAX) begin
               state_nxt = S_COMMIT;
               err_nxt   = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         S_COMMIT: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         err_p1      <= 1'b0;
         pc_p1       <= '0;
         rd_p1       <= '0;
         rd_data_p1  <= '0;
         reg_wr_p1   <= 1'b0;
         load_p1     <= 1'b0;
         store_p1    <= 1'b0;
         csr_ctl_p1  <= '0;
         csr_addr_p1 <= '0;
         csr_data_p1 <= '0;
         mem_data_p1 <= '0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         err_p1 <= err_nxt;
         // Capture stage: fields are frozen from handshake until the next one.
         if (hs) begin
            pc_p1       <= in_pc;
            rd_p1       <= in_rd;
            rd_data_p1  <= in_rd_data;
            reg_wr_p1   <= in_reg_wr;
            load_p1     <= in_load;
            store_p1    <= in_store && !in_load;
            csr_ctl_p1  <= (in_csr_ctl == 2'b11) ? 2'b00 : in_csr_ctl;
            csr_addr_p1 <= in_csr_addr;
            csr_data_p1 <= in_csr_data;
         end
         if ((state == S_WAIT_MEM) && load_p1 && mem_rvalid) begin
            mem_data_p1 <= mem_rdata;
         end
      end
   end

   // Commit stage: reset overrides the outputs combinationally so an aborted commit never writes.
   always_comb begin
      commit       = (state == S_COMMIT) && !rst;
      in_ready     = rst || (state == S_IDLE);
      gpr_we       = commit && reg_wr_p1 && !store_p1 && (rd_p1 != 5'd0) && !err_p1;
      gpr_waddr    = rst ? 5'd0 : rd_p1;
      gpr_wdata    = rst ? 32'd0 : (load_p1 ? mem_data_p1 : rd_data_p1);
      csr_we       = commit && (csr_ctl_p1 == 2'b00) && reg_wr_p1 && !err_p1
                     && csr_writable(csr_addr_p1);
      csr_waddr    = rst ? 12'd0 : csr_addr_p1;
      csr_wdata    = rst ? 32'd0 : csr_data_p1;
      ecall_we     = commit && (csr_ctl_p1 == 2'b01);
      ecall_pc     = rst ? 32'd0 : pc_p1;
      commit_valid = commit;
      commit_pc    = rst ? 32'd0 : pc_p1;
      commit_err   = commit && err_p1;
   end

endmodule
